// File: rtl/subset_result_packer_if.sv
// Stream bundle between the subset-check result source, the packer and the word consumer.
// The master modport is the side that produces result bits and consumes packed words.
interface subset_result_packer_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_word;
  logic [CNT_W-1:0] out_count;
  logic [CNT_W-1:0] out_hits;

  modport master (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_word, out_count, out_hits
  );

  modport slave (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_word, out_count, out_hits
  );
endinterface

// File: rtl/subset_result_packer.sv
// Packs a stream of subset-check verdict bits LSB-first into WIDTH-bit words,
// presenting each word with its bit count and its number of hits.
module subset_result_packer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  subset_result_packer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] fill;
  logic [CNT_W-1:0] hits;
  logic [WIDTH-1:0] word;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] packed_word;
  logic [CNT_W-1:0] packed_count;
  logic [CNT_W-1:0] packed_hits;

  logic             accept;
  logic             closing;
  logic [WIDTH-1:0] word_next;
  logic [CNT_W-1:0] fill_next;
  logic [CNT_W-1:0] hits_next;

  always_comb begin
    accept    = bus.in_valid && ready;
    word_next = word | ({{(WIDTH-1){1'b0}}, bus.in_bit} << fill);
    fill_next = fill + CNT_W'(1);
    hits_next = hits + CNT_W'(bus.in_bit);
    closing   = (fill_next == CNT_W'(WIDTH)) || bus.in_last;
  end

  // in_ready is kept as a register that mirrors "not in HOLD", so it stays low
  // while in reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      fill         <= '0;
      hits         <= '0;
      word         <= '0;
      ready        <= 1'b0;
      valid        <= 1'b0;
      packed_word  <= '0;
      packed_count <= '0;
      packed_hits  <= '0;
    end else begin
      case (state)
        IDLE, FILL: begin
          ready <= 1'b1;
          if (accept) begin
            word <= word_next;
            fill <= fill_next;
            hits <= hits_next;
            if (closing) begin
              state        <= HOLD;
              ready        <= 1'b0;
              valid        <= 1'b1;
              packed_word  <= word_next;
              packed_count <= fill_next;
              packed_hits  <= hits_next;
            end else begin
              state <= FILL;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state        <= IDLE;
            fill         <= '0;
            hits         <= '0;
            word         <= '0;
            ready        <= 1'b1;
            valid        <= 1'b0;
            packed_word  <= '0;
            packed_count <= '0;
            packed_hits  <= '0;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid;
  assign bus.out_word  = packed_word;
  assign bus.out_count = packed_count;
  assign bus.out_hits  = packed_hits;

endmodule

// File: tb/tb_subset_result_packer.sv
// Directed bench for subset_result_packer: a WIDTH=4 instance for most scenarios
// and a WIDTH=32 instance for the full-width all-ones word.
module tb_subset_result_packer;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  subset_result_packer_if #(.WIDTH(4))  bus4 ();
  subset_result_packer_if #(.WIDTH(32)) bus32 ();

  subset_result_packer #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  subset_result_packer #(.WIDTH(32)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drives one bit for one edge on the narrow instance, then drops in_valid.
  task automatic send4(input logic b, input logic l);
    bus4.in_valid = 1'b1;
    bus4.in_bit   = b;
    bus4.in_last  = l;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    bus4.in_bit   = 1'b0;
    bus4.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if (bus4.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_out_valid: got %b expected 0", bus4.out_valid);
    end
    vectors++;
    if (bus4.out_word !== 4'h0 || bus4.out_count !== 3'd0 || bus4.out_hits !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got word=%h count=%0d hits=%0d expected 0/0/0",
               bus4.out_word, bus4.out_count, bus4.out_hits);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bus4.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ready_after_release: got %b expected 1", bus4.in_ready);
    end
    send4(1'b1, 1'b0);
    send4(1'b1, 1'b0);
    send4(1'b1, 1'b0);
    vectors++;
    if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL three_held: got valid=%b ready=%b expected 0/1",
               bus4.out_valid, bus4.in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus4.out_valid !== 1'b0 || bus4.out_word !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got valid=%b word=%h expected 0/0",
               bus4.out_valid, bus4.out_word);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Held bits were discarded, so only the 4th fresh bit closes the word.
    send4(1'b0, 1'b0);
    send4(1'b1, 1'b0);
    send4(1'b0, 1'b0);
    vectors++;
    if (bus4.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_discard: got valid=%b expected 0 after 3 fresh bits", bus4.out_valid);
    end
    send4(1'b0, 1'b0);
    vectors++;
    if (bus4.out_valid !== 1'b1 || bus4.out_word !== 4'b0010 ||
        bus4.out_count !== 3'd4 || bus4.out_hits !== 3'd1) begin
      miscompares++;
      $display("[TB] FAIL fresh_word: got valid=%b word=%h count=%0d hits=%0d expected 1/2/4/1",
               bus4.out_valid, bus4.out_word, bus4.out_count, bus4.out_hits);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_word();
    send4(1'b1, 1'b0);
    send4(1'b0, 1'b0);
    send4(1'b1, 1'b0);
    vectors++;
    if (bus4.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_early: got valid=%b expected 0", bus4.out_valid);
    end
    send4(1'b1, 1'b0);
    vectors++;
    if (bus4.out_valid !== 1'b1 || bus4.out_word !== 4'b1101 ||
        bus4.out_count !== 3'd4 || bus4.out_hits !== 3'd3) begin
      miscompares++;
      $display("[TB] FAIL full_word: got valid=%b word=%h count=%0d hits=%0d expected 1/d/4/3",
               bus4.out_valid, bus4.out_word, bus4.out_count, bus4.out_hits);
    end
    vectors++;
    if (bus4.in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_hold_ready: got %b expected 0", bus4.in_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1 || bus4.out_word !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL full_drain: got valid=%b ready=%b word=%h expected 0/1/0",
               bus4.out_valid, bus4.in_ready, bus4.out_word);
    end
  endtask

  task automatic test_partial();
    send4(1'b1, 1'b0);
    send4(1'b1, 1'b1);
    vectors++;
    if (bus4.out_valid !== 1'b1 || bus4.out_word !== 4'b0011 ||
        bus4.out_count !== 3'd2 || bus4.out_hits !== 3'd2) begin
      miscompares++;
      $display("[TB] FAIL partial: got valid=%b word=%h count=%0d hits=%0d expected 1/3/2/2",
               bus4.out_valid, bus4.out_word, bus4.out_count, bus4.out_hits);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bus4.out_ready = 1'b0;
    send4(1'b0, 1'b0);
    send4(1'b1, 1'b0);
    send4(1'b1, 1'b0);
    send4(1'b0, 1'b0);
    bus4.in_valid = 1'b1;
    bus4.in_bit   = 1'b1;
    bus4.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus4.out_valid !== 1'b1 || bus4.out_word !== 4'b0110 || bus4.out_count !== 3'd4 ||
          bus4.out_hits !== 3'd2 || bus4.in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall_%0d: got valid=%b word=%h count=%0d hits=%0d ready=%b expected 1/6/4/2/0",
                 i, bus4.out_valid, bus4.out_word, bus4.out_count, bus4.out_hits, bus4.in_ready);
      end
      @(posedge clk); #1;
    end
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stall_release: got valid=%b ready=%b expected 0/1",
               bus4.out_valid, bus4.in_ready);
    end
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    bus4.in_bit   = 1'b0;
    bus4.in_last  = 1'b0;
    vectors++;
    if (bus4.out_valid !== 1'b1 || bus4.out_word !== 4'b0001 ||
        bus4.out_count !== 3'd1 || bus4.out_hits !== 3'd1) begin
      miscompares++;
      $display("[TB] FAIL held_bit_word: got valid=%b word=%h count=%0d hits=%0d expected 1/1/1/1",
               bus4.out_valid, bus4.out_word, bus4.out_count, bus4.out_hits);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_last_at_width();
    send4(1'b0, 1'b0);
    send4(1'b0, 1'b0);
    send4(1'b0, 1'b0);
    send4(1'b1, 1'b1);
    vectors++;
    if (bus4.out_valid !== 1'b1 || bus4.out_word !== 4'b1000 ||
        bus4.out_count !== 3'd4 || bus4.out_hits !== 3'd1) begin
      miscompares++;
      $display("[TB] FAIL last_at_width: got valid=%b word=%h count=%0d hits=%0d expected 1/8/4/1",
               bus4.out_valid, bus4.out_word, bus4.out_count, bus4.out_hits);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus4.out_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL no_trailing_%0d: got valid=%b expected 0", i, bus4.out_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wide();
    for (int i = 0; i < 32; i++) begin
      bus32.in_valid = 1'b1;
      bus32.in_bit   = 1'b1;
      bus32.in_last  = 1'b0;
      @(posedge clk); #1;
      if (i == 30) begin
        vectors++;
        if (bus32.out_valid !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL wide_early: got valid=%b expected 0 after 31 bits", bus32.out_valid);
        end
      end
    end
    bus32.in_valid = 1'b0;
    bus32.in_bit   = 1'b0;
    vectors++;
    if (bus32.out_valid !== 1'b1 || bus32.out_word !== 32'hFFFF_FFFF ||
        bus32.out_count !== 6'd32 || bus32.out_hits !== 6'd32) begin
      miscompares++;
      $display("[TB] FAIL wide_word: got valid=%b word=%h count=%0d hits=%0d expected 1/ffffffff/32/32",
               bus32.out_valid, bus32.out_word, bus32.out_count, bus32.out_hits);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus32.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wide_drain: got valid=%b expected 0", bus32.out_valid);
    end
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    rst_n           = 1'b0;
    bus4.in_valid   = 1'b0;
    bus4.in_bit     = 1'b0;
    bus4.in_last    = 1'b0;
    bus4.out_ready  = 1'b1;
    bus32.in_valid  = 1'b0;
    bus32.in_bit    = 1'b0;
    bus32.in_last   = 1'b0;
    bus32.out_ready = 1'b1;
    #12;
    test_reset();
    test_full_word();
    test_partial();
    test_backpressure();
    test_last_at_width();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
